// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped read-only cache.
// Holds the default geometry, the address-field widths derived from it,
// the controller state encoding and a packed view of a byte address.
// The top module takes its parameter defaults from the DEF_* values here.
// Its field slicing uses the derived widths below, so any change to the
// geometry must be made in this package.
package cache_pkg;

    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_LINES          = 64;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_CNT_W          = 16;

    localparam int BYTE_W = $clog2(DEF_DATA_W / 8);
    localparam int OFF_W  = $clog2(DEF_WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(DEF_LINES);
    localparam int TAG_W  = DEF_ADDR_W - IDX_W - OFF_W - BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_REFILL,
        ST_RESPOND
    } cache_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  index;
        logic [OFF_W-1:0]  word;
        logic [BYTE_W-1:0] byte_off;
    } addr_fields_t;

    // Byte address of the first word of the line holding the given address.
    function automatic logic [DEF_ADDR_W-1:0] line_base(input addr_fields_t f);
        return {f.tag, f.index, {(OFF_W + BYTE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid-bit and tag arrays for the direct-mapped cache.
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset (valid bits only)
//   rd_idx_i                combinational read index
//   rd_valid_o, rd_tag_o    valid bit and tag stored at rd_idx_i
//   wr_en_i, wr_idx_i,      synchronous tag write; also sets the valid bit
//   wr_tag_i
//   clr_en_i, clr_idx_i     synchronous clear of one valid bit
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int LINES    = DEF_LINES,
    parameter int IX_W     = IDX_W,
    parameter int TG_W     = TAG_W
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [IX_W-1:0] rd_idx_i,
    output logic            rd_valid_o,
    output logic [TG_W-1:0] rd_tag_o,
    input  logic            wr_en_i,
    input  logic [IX_W-1:0] wr_idx_i,
    input  logic [TG_W-1:0] wr_tag_i,
    input  logic            clr_en_i,
    input  logic [IX_W-1:0] clr_idx_i
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TG_W-1:0]  tag_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (clr_en_i) begin
            valid_d[clr_idx_i] = 1'b0;
        end
        if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag contents are meaningless while the valid bit is clear, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];

endmodule

// File: rtl/cache_direct_mapped.sv
// Read-only direct-mapped L1 cache with line refill from backing memory.
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        core access handshake, req_addr_i byte address
//   resp_valid_o, hit_o, data_o    one-cycle response pulse with hit flag and word
//   mem_req_valid_o/mem_req_ready_i, mem_req_addr_o   line refill request
//   mem_rsp_valid_i, mem_rsp_data_i                   refill beats, word 0 first
//   hit_count_o, miss_count_o      saturating access statistics
module cache_direct_mapped
    import cache_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              resp_valid_o,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    output logic [CNT_W-1:0]  hit_count_o,
    output logic [CNT_W-1:0]  miss_count_o
);

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    cache_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [DATA_W-1:0] data_q [LINES * WORDS_PER_LINE];

    addr_fields_t fld;
    logic         unused_byte_off;
    logic         tag_valid;
    logic [TAG_W-1:0] tag_rd;
    logic         lookup_hit;
    logic         tag_we;
    logic         valid_clr;
    logic         data_we;

    assign fld             = addr_fields_t'(addr_q);
    assign unused_byte_off = ^fld.byte_off;
    assign lookup_hit      = tag_valid && (tag_rd == fld.tag);

    cache_tag_store #(
        .LINES (LINES),
        .IX_W  (IDX_W),
        .TG_W  (TAG_W)
    ) u_tag_store (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rd_idx_i   (fld.index),
        .rd_valid_o (tag_valid),
        .rd_tag_o   (tag_rd),
        .wr_en_i    (tag_we),
        .wr_idx_i   (fld.index),
        .wr_tag_i   (fld.tag),
        .clr_en_i   (valid_clr),
        .clr_idx_i  (fld.index)
    );

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        req_ready_o     = 1'b0;
        resp_valid_o    = 1'b0;
        hit_o           = 1'b0;
        data_o          = '0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        tag_we          = 1'b0;
        valid_clr       = 1'b0;
        data_we         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lookup_hit) begin
                    resp_valid_o = 1'b1;
                    hit_o        = 1'b1;
                    data_o       = data_q[{fld.index, fld.word}];
                    hit_cnt_d    = sat_inc(hit_cnt_q);
                    // Accepting during a hit gives one access per cycle.
                    req_ready_o  = 1'b1;
                    if (req_valid_i) begin
                        addr_d = req_addr_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    // Invalidate first so an abandoned refill never leaves a half-filled line valid.
                    valid_clr  = 1'b1;
                    state_d    = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = line_base(fld);
                if (mem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_rsp_valid_i) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        tag_we  = 1'b1;
                        state_d = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                // The whole line is in the array by now, so read the word back from it.
                resp_valid_o = 1'b1;
                data_o       = data_q[{fld.index, fld.word}];
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_q[{fld.index, cnt_q}] <= mem_rsp_data_i;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_cache_direct_mapped.sv
// Directed bench for cache_direct_mapped. The memory side is driven inline:
// word data equals its byte address, and the request is accepted after a
// configurable number of wait cycles.
module tb_cache_direct_mapped;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        resp_valid;
    logic        hit;
    logic [31:0] data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_direct_mapped dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .resp_valid_o    (resp_valid),
        .hit_o           (hit),
        .data_o          (data),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data),
        .hit_count_o     (hit_count),
        .miss_count_o    (miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Enters at posedge+1 in IDLE; leaves at posedge+1 in MISS_REQ.
    task automatic issue_lookup_miss(input logic [15:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("lookup_miss_resp", 32'(resp_valid), 32'd0);
        chk("lookup_miss_ready", 32'(req_ready), 32'd0);
        cyc();
    endtask

    // Memory accepts the line request after w cycles; leaves in REFILL.
    task automatic mem_handshake(input logic [15:0] line, input int w);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            chk("mreq_valid_wait", 32'(mem_req_valid), 32'd1);
            chk("mreq_addr_wait", 32'(mem_req_addr), 32'(line));
            chk("mreq_core_ready", 32'(req_ready), 32'd0);
            cyc();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("mreq_valid_hs", 32'(mem_req_valid), 32'd1);
        chk("mreq_addr_hs", 32'(mem_req_addr), 32'(line));
        cyc();
        mem_req_ready = 1'b0;
    endtask

    task automatic beats(input logic [15:0] line, input int n);
        for (int i = 0; i < n; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'({16'h0, line}) + 32'(i * 4);
            @(negedge clk);
            chk("refill_resp", 32'(resp_valid), 32'd0);
            chk("refill_mreq", 32'(mem_req_valid), 32'd0);
            cyc();
        end
        mem_rsp_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] exp_d);
        @(negedge clk);
        chk("miss_resp_valid", 32'(resp_valid), 32'd1);
        chk("miss_resp_hit", 32'(hit), 32'd0);
        chk("miss_resp_data", data, exp_d);
        cyc();
        @(negedge clk);
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_resp_ready", 32'(req_ready), 32'd1);
        cyc();
    endtask

    task automatic miss_access(input logic [15:0] a, input int w, input logic [31:0] exp_d);
        issue_lookup_miss(a);
        mem_handshake(a & 16'hFFF0, w);
        beats(a & 16'hFFF0, 4);
        respond(exp_d);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_mreq", 32'(mem_req_valid), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        chk("rst_misses", 32'(miss_count), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Cold miss on line 0.
        miss_access(16'h0000, 2, 32'h0000_0000);
        chk("cold_misses", 32'(miss_count), 32'd1);
        chk("cold_hits", 32'(hit_count), 32'd0);

        // Three back-to-back hits in the freshly filled line.
        req_valid = 1'b1;
        req_addr  = 16'h0004;
        @(negedge clk);
        chk("b2b_ready0", 32'(req_ready), 32'd1);
        cyc();
        req_addr = 16'h0008;
        @(negedge clk);
        chk("b2b_resp4", 32'(resp_valid), 32'd1);
        chk("b2b_hit4", 32'(hit), 32'd1);
        chk("b2b_data4", data, 32'h4);
        chk("b2b_ready4", 32'(req_ready), 32'd1);
        cyc();
        req_addr = 16'h000C;
        @(negedge clk);
        chk("b2b_resp8", 32'(resp_valid), 32'd1);
        chk("b2b_data8", data, 32'h8);
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_respC", 32'(resp_valid), 32'd1);
        chk("b2b_hitC", 32'(hit), 32'd1);
        chk("b2b_dataC", data, 32'hC);
        cyc();
        @(negedge clk);
        chk("b2b_idle_resp", 32'(resp_valid), 32'd0);
        chk("b2b_hits", 32'(hit_count), 32'd3);
        cyc();

        // Conflict on index 0: tag 1 evicts tag 0, then tag 0 evicts tag 1.
        miss_access(16'h0400, 2, 32'h0000_0400);
        miss_access(16'h0000, 2, 32'h0000_0000);
        chk("conflict_misses", 32'(miss_count), 32'd3);
        chk("conflict_hits", 32'(hit_count), 32'd3);

        // Long memory stall: request held stable for 10 cycles.
        miss_access(16'h0108, 10, 32'h0000_0108);
        chk("stall_misses", 32'(miss_count), 32'd4);

        // Reset in the middle of a refill, then stray beats.
        issue_lookup_miss(16'h0800);
        mem_handshake(16'h0800, 2);
        beats(16'h0800, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp", 32'(resp_valid), 32'd0);
        chk("midrst_data", data, 32'd0);
        chk("midrst_mreq", 32'(mem_req_valid), 32'd0);
        chk("midrst_mreq_addr", 32'(mem_req_addr), 32'd0);
        chk("midrst_hits", 32'(hit_count), 32'd0);
        chk("midrst_misses", 32'(miss_count), 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'h0000_0808 + 32'(i * 4);
            @(negedge clk);
            chk("stray_resp", 32'(resp_valid), 32'd0);
            chk("stray_mreq", 32'(mem_req_valid), 32'd0);
            chk("stray_ready", 32'(req_ready), 32'd1);
            cyc();
        end
        mem_rsp_valid = 1'b0;
        miss_access(16'h0800, 2, 32'h0000_0800);
        chk("rerun_misses", 32'(miss_count), 32'd1);

        // Hit counter saturation: 65540 hits to 0x0004.
        miss_access(16'h0004, 2, 32'h0000_0004);
        chk("sat_misses", 32'(miss_count), 32'd2);
        req_valid = 1'b1;
        req_addr  = 16'h0004;
        repeat (100) cyc();
        @(negedge clk);
        chk("sat_mid_resp", 32'(resp_valid), 32'd1);
        chk("sat_mid_data", data, 32'h4);
        chk("sat_mid_hits", 32'(hit_count), 32'd99);
        repeat (65440) cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("sat_last_hit", 32'(hit), 32'd1);
        chk("sat_before_last", 32'(hit_count), 32'hFFFF);
        cyc();
        @(negedge clk);
        chk("sat_final_hits", 32'(hit_count), 32'hFFFF);
        chk("sat_final_resp", 32'(resp_valid), 32'd0);
        chk("sat_final_misses", 32'(miss_count), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
